// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the per-lane clock-gate enable sequencer.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_ON   = 2'd0,
        CG_OFF  = 2'd1,
        CG_WAKE = 2'd2
    } clk_gate_state_e;

    // Counter width wide enough for both the idle and the wake reload values.
    function automatic int unsigned cnt_width(input int unsigned idle_cycles,
                                              input int unsigned wake_cycles);
        int unsigned max_cycles;
        max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Sequencer <-> gate controller bundle: requests in, enables/grants/status out.
interface clk_gate_ctrl_if #(
    parameter int unsigned NrUnits = 4
) ();
    import clk_gate_ctrl_pkg::*;

    logic               testmode_i;
    logic               force_on_i;
    logic [NrUnits-1:0] busy_i;
    logic [NrUnits-1:0] wake_req_i;
    logic [NrUnits-1:0] wake_gnt_o;
    logic [NrUnits-1:0] en_o;
    logic               te_o;
    logic [NrUnits-1:0] gated_o;
    logic               err_o;

    modport master (
        output testmode_i, force_on_i, busy_i, wake_req_i,
        input  wake_gnt_o, en_o, te_o, gated_o, err_o
    );

    modport slave (
        input  testmode_i, force_on_i, busy_i, wake_req_i,
        output wake_gnt_o, en_o, te_o, gated_o, err_o
    );

endinterface

// File: rtl/clk_gate_unit_fsm.sv
// One unit's ON/OFF/WAKE gating FSM with shared idle/settle counter.
module clk_gate_unit_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic testmode_i,
    input  logic force_on_i,
    input  logic busy_i,
    input  logic wake_req_i,
    output logic wake_gnt_o,
    output logic en_o,
    output logic gated_o,
    output logic err_c
);

    localparam int unsigned CntWidth = cnt_width(IdleCycles, WakeCycles);
    localparam logic [CntWidth-1:0] IdleLoad = CntWidth'(IdleCycles);
    localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WakeCycles);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntZero  = CntWidth'(0);

    clk_gate_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                keep_on;
    logic                wake_cause;

    assign keep_on    = busy_i | wake_req_i | force_on_i | testmode_i;
    assign wake_cause = wake_req_i | force_on_i | testmode_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CG_ON;
            cnt_q   <= IdleLoad;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    // Activity in ON always wins over the final idle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        unique case (state_q)
            CG_ON: begin
                en_d = 1'b1;
                if (keep_on) begin
                    cnt_d = IdleLoad;
                end else if (cnt_q == CntOne) begin
                    state_d = CG_OFF;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            CG_OFF: begin
                en_d = 1'b0;
                if (wake_cause) begin
                    state_d = CG_WAKE;
                    en_d    = 1'b1;
                    cnt_d   = WakeLoad;
                end
            end
            CG_WAKE: begin
                en_d = 1'b1;
                if (cnt_q == CntZero) begin
                    state_d = CG_ON;
                    cnt_d   = IdleLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = CG_ON;
                cnt_d   = IdleLoad;
                en_d    = 1'b1;
            end
        endcase
    end

    // Scan forces the enable high on top of the flop; grant never looks at the counter.
    assign en_o       = en_q | testmode_i;
    assign wake_gnt_o = (state_q == CG_ON) & wake_req_i & ~rst_i;
    assign gated_o    = (state_q == CG_OFF);
    assign err_c      = (state_q == CG_OFF) & busy_i & ~rst_i;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Lane clock-gate enable sequencer: one independent FSM per functional unit.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned NrUnits    = 4,
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    clk_gate_ctrl_if.slave bus
);

    logic [NrUnits-1:0] unit_gnt;
    logic [NrUnits-1:0] unit_en;
    logic [NrUnits-1:0] unit_gated;
    logic [NrUnits-1:0] unit_err;
    logic               err_q;

    for (genvar g = 0; g < NrUnits; g++) begin : gen_unit
        clk_gate_unit_fsm #(
            .IdleCycles (IdleCycles),
            .WakeCycles (WakeCycles)
        ) u_unit (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .testmode_i (bus.testmode_i),
            .force_on_i (bus.force_on_i),
            .busy_i     (bus.busy_i[g]),
            .wake_req_i (bus.wake_req_i[g]),
            .wake_gnt_o (unit_gnt[g]),
            .en_o       (unit_en[g]),
            .gated_o    (unit_gated[g]),
            .err_c      (unit_err[g])
        );
    end

    // Sticky error: only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (|unit_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.wake_gnt_o = unit_gnt;
    assign bus.en_o       = unit_en;
    assign bus.gated_o    = unit_gated;
    assign bus.err_o      = err_q;
    assign bus.te_o       = bus.testmode_i;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl against a cycle-count reference model.
module tb_clk_gate_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned IDLE = 16;
    localparam int unsigned WAKE = 2;

    typedef struct packed {
        logic [N-1:0] en;
        logic [N-1:0] gnt;
        logic [N-1:0] gated;
        logic         te;
        logic         err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_gate_ctrl_if #(.NrUnits(N)) bus ();

    clk_gate_ctrl #(
        .NrUnits    (N),
        .IdleCycles (IDLE),
        .WakeCycles (WAKE)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model: gated flag, remaining settle cycles, consecutive idle streak.
    bit   m_off    [N];
    bit   m_waking [N];
    int   m_wait   [N];
    int   m_streak [N];
    bit   m_err;

    obs_t sb[$];
    obs_t last_exp;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    function automatic void model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_off[i] = 0; m_waking[i] = 0; m_wait[i] = 0; m_streak[i] = 0;
            end
            m_err = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_off[i]) begin
                if (bus.busy_i[i]) m_err = 1;
                if (bus.wake_req_i[i] || bus.force_on_i || bus.testmode_i) begin
                    m_off[i]    = 0;
                    m_waking[i] = 1;
                    m_wait[i]   = WAKE + 1;
                end
            end else if (m_waking[i]) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_waking[i] = 0;
                    m_streak[i] = 0;
                end
            end else if (bus.busy_i[i] || bus.wake_req_i[i] || bus.force_on_i || bus.testmode_i) begin
                m_streak[i] = 0;
            end else begin
                m_streak[i]++;
                if (m_streak[i] == IDLE) begin
                    m_off[i]    = 1;
                    m_streak[i] = 0;
                end
            end
        end
    endfunction

    function automatic obs_t predict();
        obs_t e;
        for (int i = 0; i < N; i++) begin
            e.en[i]    = !m_off[i] || bus.testmode_i;
            e.gnt[i]   = !m_off[i] && !m_waking[i] && bus.wake_req_i[i] && !rst;
            e.gated[i] = m_off[i];
        end
        e.te  = bus.testmode_i;
        e.err = m_err;
        return e;
    endfunction

    // One cycle: advance the model over the edge, then drive and predict the new cycle.
    task automatic apply(input logic r, input logic tm, input logic fo,
                         input logic [N-1:0] b, input logic [N-1:0] rq);
        @(posedge clk);
        model_step();
        #1;
        rst            = r;
        bus.testmode_i = tm;
        bus.force_on_i = fo;
        bus.busy_i     = b;
        bus.wake_req_i = rq;
        cyc++;
        last_exp = predict();
        sb.push_back(last_exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: every cycle presents one observation at mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t e, a;
                e = sb.pop_front();
                a.en = bus.en_o; a.gnt = bus.wake_gnt_o; a.gated = bus.gated_o;
                a.te = bus.te_o; a.err = bus.err_o;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs cyc=%0d en=%h/%h gnt=%h/%h gated=%h/%h te=%b/%b err=%b/%b (actual/required)",
                             cyc, a.en, e.en, a.gnt, e.gnt, a.gated, e.gated, a.te, e.te, a.err, e.err);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rq_hold;
        logic [N-1:0] busy_r;
        logic         fo_r, tm_r, rst_r;
        int           k;

        rst = 1'b1;
        bus.testmode_i = 1'b0; bus.force_on_i = 1'b0;
        bus.busy_i = '0; bus.wake_req_i = '0;

        // Reset, then pure idle until all units gate.
        apply(1'b1, 1'b0, 1'b0, '0, '0);
        apply(1'b1, 1'b0, 1'b0, '0, '0);
        idle(20);

        // Wake unit0 from OFF and hold the request until granted.
        k = 0;
        apply(1'b0, 1'b0, 1'b0, '0, 4'b0001);
        while (!last_exp.gnt[0] && k < 10) begin
            apply(1'b0, 1'b0, 1'b0, '0, 4'b0001);
            k++;
        end
        if (k >= 10) begin
            miscompares++;
            $display("FAIL wake_budget waited=%0d limit=%0d", k, 10);
        end
        idle(4);

        // Busy pulses on unit1: period 15 keeps it on, period 17 lets it gate.
        apply(1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 60; c++) apply(1'b0, 1'b0, 1'b0, (c % 15 == 0) ? 4'b0010 : 4'b0000, '0);
        for (int c = 0; c < 70; c++) apply(1'b0, 1'b0, 1'b0, (c % 17 == 0) ? 4'b0010 : 4'b0000, '0);

        // Request lands on the last idle cycle before gating.
        apply(1'b1, 1'b0, 1'b0, '0, '0);
        idle(15);
        apply(1'b0, 1'b0, 1'b0, '0, 4'b1111);
        idle(20);

        // Force-on from all OFF; hold well past the idle window.
        for (int c = 0; c < 30; c++) apply(1'b0, 1'b0, 1'b1, '0, '0);
        idle(20);

        // Busy on a gated unit raises the sticky error.
        apply(1'b0, 1'b0, 1'b0, 4'b0100, '0);
        idle(5);

        // Reset in the middle of WAKE.
        apply(1'b0, 1'b0, 1'b0, '0, 4'b1111);
        apply(1'b0, 1'b0, 1'b0, '0, 4'b1111);
        apply(1'b1, 1'b0, 1'b0, '0, '0);
        idle(20);

        // Scan mode from OFF.
        for (int c = 0; c < 5; c++) apply(1'b0, 1'b1, 1'b0, 4'b0101, '0);
        idle(22);

        // Random traffic with held requests.
        rq_hold = '0; fo_r = 1'b0; tm_r = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq_hold[i] && last_exp.gnt[i] && $urandom_range(1, 0) == 1) rq_hold[i] = 1'b0;
                else if (!rq_hold[i] && $urandom_range(40, 0) == 0) rq_hold[i] = 1'b1;
                busy_r[i] = ($urandom_range(60, 0) == 0);
            end
            if ($urandom_range(80, 0) == 0) fo_r = ~fo_r;
            if ($urandom_range(120, 0) == 0) tm_r = ~tm_r;
            rst_r = ($urandom_range(400, 0) == 0);
            apply(rst_r, tm_r, fo_r, busy_r, rq_hold);
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=%0d", sb.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
